// File: rtl/ext_mem_arb_pkg.sv
// Shared types and helpers for the external-memory arbiter.
// Contents:
//   ArbNbReq  - requester count the package types are sized for
//   req_idx_t - requester index
//   rd_tag_t  - {valid, idx} tag carried alongside an outstanding read
//   rr_next() - round-robin pointer advance (grantee + 1, wrapping to 0)
package ext_mem_arb_pkg;

  localparam int unsigned ArbNbReq = 2;
  localparam int unsigned ArbIdxW  = (ArbNbReq > 1) ? $clog2(ArbNbReq) : 1;

  typedef logic [ArbIdxW-1:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } rd_tag_t;

  localparam req_idx_t LastIdx = req_idx_t'(ArbNbReq - 1);

  function automatic req_idx_t rr_next(input req_idx_t ptr);
    return (ptr == LastIdx) ? '0 : ptr + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the pointer,
// wrapping N-1 -> 0. The grant is combinational.
// Ports:
//   clk, arst_n - clock, asynchronous active-low reset
//   req         - request vector
//   update_en   - allow the pointer to advance past this cycle's grantee
//   gnt         - one-hot grant (zero when no request)
//   gnt_idx     - index of the grantee (0 when no request)
module rr_arbiter
  import ext_mem_arb_pkg::*;
#(
  parameter int unsigned N = ArbNbReq
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] gnt,
  output req_idx_t     gnt_idx
);

  req_idx_t    ptr_q, ptr_d;
  logic        found;
  int unsigned j;
  req_idx_t    k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    k       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N) j = j - N;
      k = req_idx_t'(j);
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_en && found) ptr_d = rr_next(gnt_idx);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares one external-memory read port and one write port between NB_REQ requesters.
// Each port has its own round-robin arbiter; grants are combinational and a transfer
// completes in the cycle valid & ready. Read data returns READ_LATENCY cycles after the
// grant on the shared rsp_data bus, flagged one-hot on rsp_valid.
// NB_REQ must equal ext_mem_arb_pkg::ArbNbReq (tag/index types are sized from it).
// Optional build macro ARB_RAW_GUARD_EN: a same-cycle granted read and write to the same
// address holds off the read grant for that cycle so the read sees the new data.
// Ports:
//   clk, arst_n_in                   - clock, asynchronous active-low reset
//   rd_valid/rd_addr/rd_ready        - per-requester read request handshake
//   rsp_valid/rsp_data               - read response (one-hot valid, shared data)
//   wr_valid/wr_addr/wr_data/wr_ready- per-requester write request handshake
//   ext_mem_*                        - external memory pins
module ext_mem_arbiter
  import ext_mem_arb_pkg::*;
#(
  parameter int unsigned NB_REQ       = ArbNbReq,
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic [NB_REQ-1:0]            rd_valid,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NB_REQ-1:0]            rd_ready,
  output logic [NB_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  input  logic [NB_REQ-1:0]            wr_valid,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NB_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NB_REQ-1:0]            wr_ready,
  output logic                         ext_mem_read_en,
  output logic [ADDR_WIDTH-1:0]        ext_mem_read_addr,
  input  logic [DATA_WIDTH-1:0]        ext_mem_qout,
  output logic                         ext_mem_write_en,
  output logic [ADDR_WIDTH-1:0]        ext_mem_write_addr,
  output logic [DATA_WIDTH-1:0]        ext_mem_din
);

  logic [NB_REQ-1:0]     rd_req, wr_req, rd_gnt, wr_gnt;
  req_idx_t              rd_idx, wr_idx;
  logic                  rd_any, wr_any, raw_hit;
  logic [ADDR_WIDTH-1:0] rd_addr_sel, wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  rd_tag_t               tag_q [READ_LATENCY];
  rd_tag_t               tail;

  // Requests are masked while reset is held so no grant or enable escapes.
  assign rd_req = rd_valid & {NB_REQ{arst_n_in}};
  assign wr_req = wr_valid & {NB_REQ{arst_n_in}};

  rr_arbiter #(.N(NB_REQ)) u_rd_arb (
    .clk       (clk),
    .arst_n    (arst_n_in),
    .req       (rd_req),
    .update_en (~raw_hit),
    .gnt       (rd_gnt),
    .gnt_idx   (rd_idx)
  );

  rr_arbiter #(.N(NB_REQ)) u_wr_arb (
    .clk       (clk),
    .arst_n    (arst_n_in),
    .req       (wr_req),
    .update_en (1'b1),
    .gnt       (wr_gnt),
    .gnt_idx   (wr_idx)
  );

  always_comb begin
    rd_any      = |rd_gnt;
    wr_any      = |wr_gnt;
    rd_addr_sel = rd_addr[32'(rd_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    wr_addr_sel = wr_addr[32'(wr_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    wr_data_sel = wr_data[32'(wr_idx) * DATA_WIDTH +: DATA_WIDTH];
`ifdef ARB_RAW_GUARD_EN
    raw_hit = rd_any && wr_any && (rd_addr_sel == wr_addr_sel);
`else
    raw_hit = 1'b0;
`endif
  end

  always_comb begin
    rd_ready           = raw_hit ? '0 : rd_gnt;
    wr_ready           = wr_gnt;
    ext_mem_read_en    = |rd_ready;
    ext_mem_read_addr  = ext_mem_read_en ? rd_addr_sel : '0;
    ext_mem_write_en   = wr_any;
    ext_mem_write_addr = wr_any ? wr_addr_sel : '0;
    ext_mem_din        = wr_any ? wr_data_sel : '0;
  end

  // Tag pipeline: stage 0 captures this cycle's read, the tail lines up with ext_mem_qout.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: ext_mem_read_en, idx: rd_idx};
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    tail      = tag_q[READ_LATENCY-1];
    rsp_valid = '0;
    rsp_data  = '0;
    if (tail.valid) begin
      rsp_valid[tail.idx] = 1'b1;
      rsp_data            = ext_mem_qout;
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: two instances (READ_LATENCY 1 and 3) share stimulus; each
// has its own behavioural memory. Grants come from a hand-derived vector table; read
// responses are predicted into per-instance queues when a grant is expected.
module tb_ext_mem_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;

  logic            clk, arst_n_in;
  logic [1:0]      rd_valid, wr_valid;
  logic [2*AW-1:0] rd_addr, wr_addr;
  logic [2*DW-1:0] wr_data;

  logic [1:0]    d1_rd_ready, d1_rsp_valid, d1_wr_ready;
  logic [DW-1:0] d1_rsp_data, d1_din, qout1;
  logic          d1_re, d1_we;
  logic [AW-1:0] d1_ra, d1_wa;
  logic [1:0]    d3_rd_ready, d3_rsp_valid, d3_wr_ready;
  logic [DW-1:0] d3_rsp_data, d3_din, qout3;
  logic          d3_re, d3_we;
  logic [AW-1:0] d3_ra, d3_wa;

  ext_mem_arbiter #(.NB_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .arst_n_in(arst_n_in),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(d1_rd_ready),
    .rsp_valid(d1_rsp_valid), .rsp_data(d1_rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(d1_wr_ready),
    .ext_mem_read_en(d1_re), .ext_mem_read_addr(d1_ra), .ext_mem_qout(qout1),
    .ext_mem_write_en(d1_we), .ext_mem_write_addr(d1_wa), .ext_mem_din(d1_din)
  );

  ext_mem_arbiter #(.NB_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .arst_n_in(arst_n_in),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(d3_rd_ready),
    .rsp_valid(d3_rsp_valid), .rsp_data(d3_rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(d3_wr_ready),
    .ext_mem_read_en(d3_re), .ext_mem_read_addr(d3_ra), .ext_mem_qout(qout3),
    .ext_mem_write_en(d3_we), .ext_mem_write_addr(d3_wa), .ext_mem_din(d3_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    if (a == 16) return 32'h0000_DEAD;
    return 32'hC0DE_0000 | a;
  endfunction

  // Behavioural memories: synchronous read (old data on same-address write), 1 or 3 cycles.
  logic          mem_clr;
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] m1_s0, m3_s0, m3_s1, m3_s2;
  assign qout1 = m1_s0;
  assign qout3 = m3_s2;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_val(i);
        mem3[i] <= init_val(i);
      end
    end else begin
      if (d1_re) m1_s0 <= mem1[d1_ra[7:0]];
      if (d1_we) mem1[d1_wa[7:0]] <= d1_din;
      if (d3_re) m3_s0 <= mem3[d3_ra[7:0]];
      if (d3_we) mem3[d3_wa[7:0]] <= d3_din;
      m3_s1 <= m3_s0;
      m3_s2 <= m3_s1;
    end
  end

  typedef struct {
    logic          rst;
    logic [1:0]    rv;
    logic [AW-1:0] ra0, ra1;
    logic [1:0]    wv;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [1:0]    erd, ewr;
  } vec_t;

  typedef struct {
    int unsigned   due;
    logic [1:0]    v;
    logic [DW-1:0] d;
  } rsp_t;

  vec_t          vecs[$];
  rsp_t          q1[$];
  rsp_t          q3[$];
  logic [DW-1:0] ref_mem [256];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic add(input logic rst, input logic [1:0] rv, input logic [AW-1:0] ra0,
                     input logic [AW-1:0] ra1, input logic [1:0] wv, input logic [AW-1:0] wa0,
                     input logic [AW-1:0] wa1, input logic [DW-1:0] wd0,
                     input logic [DW-1:0] wd1, input logic [1:0] erd, input logic [1:0] ewr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ra0 = ra0; v.ra1 = ra1;
    v.wv = wv; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.erd = erd; v.ewr = ewr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0]    raw_rd;
    vec_t          v;
    logic [AW-1:0] exp_ra, exp_wa;
    logic [DW-1:0] exp_wd, d;
    logic [1:0]    e1v, e3v;
    logic [DW-1:0] e1d, e3d;
    int unsigned   cyc;

`ifdef ARB_RAW_GUARD_EN
    raw_rd = 2'b00;
`else
    raw_rd = 2'b01;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    //  rst rv     ra0     ra1     wv     wa0     wa1     wd0           wd1           erd    ewr
    add(1, 2'b11, 20'h10, 20'h11, 2'b11, 20'h30, 20'h31, 32'h1111_0000, 32'h2222_0000, 2'b00, 2'b00);
    add(0, 2'b01, 20'h10, 20'h11, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b01, 2'b00);
    add(0, 2'b00, 20'h10, 20'h11, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);
    add(1, 2'b00, 20'h10, 20'h11, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);
    add(0, 2'b11, 20'h01, 20'h02, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b01, 2'b00);
    add(0, 2'b11, 20'h01, 20'h02, 2'b11, 20'h30, 20'h31, 32'h1111_0005, 32'h2222_0005, 2'b10, 2'b01);
    add(0, 2'b11, 20'h01, 20'h02, 2'b11, 20'h30, 20'h31, 32'h1111_0006, 32'h2222_0006, 2'b01, 2'b10);
    add(0, 2'b11, 20'h01, 20'h02, 2'b11, 20'h30, 20'h31, 32'h1111_0007, 32'h2222_0007, 2'b10, 2'b01);
    add(0, 2'b00, 20'h01, 20'h02, 2'b11, 20'h30, 20'h31, 32'h1111_0008, 32'h2222_0008, 2'b00, 2'b10);
    add(0, 2'b01, 20'h03, 20'h04, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b01, 2'b00);
    add(0, 2'b10, 20'h03, 20'h04, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b10, 2'b00);
    add(0, 2'b01, 20'h05, 20'h04, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b01, 2'b00);
    add(0, 2'b00, 20'h05, 20'h04, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);
    add(0, 2'b00, 20'h05, 20'h04, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);
    add(0, 2'b00, 20'h05, 20'h04, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);
    add(0, 2'b10, 20'h05, 20'h31, 2'b00, 20'h30, 20'h31, 32'h0,         32'h0,         2'b10, 2'b00);
    // Same-address read and write in one cycle.
    add(0, 2'b01, 20'h20, 20'h31, 2'b01, 20'h20, 20'h31, 32'h55,        32'h0,         raw_rd, 2'b01);
    add(0, 2'b01, 20'h20, 20'h31, 2'b00, 20'h20, 20'h31, 32'h0,         32'h0,         2'b01, 2'b00);
    add(0, 2'b00, 20'h20, 20'h31, 2'b00, 20'h20, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);
    add(0, 2'b00, 20'h20, 20'h31, 2'b00, 20'h20, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);
    add(0, 2'b00, 20'h20, 20'h31, 2'b00, 20'h20, 20'h31, 32'h0,         32'h0,         2'b00, 2'b00);

    mem_clr = 1'b1;
    cyc     = 0;
    foreach (vecs[r]) begin
      v         = vecs[r];
      arst_n_in = ~v.rst;
      rd_valid  = v.rv;
      rd_addr   = {v.ra1, v.ra0};
      wr_valid  = v.wv;
      wr_addr   = {v.wa1, v.wa0};
      wr_data   = {v.wd1, v.wd0};
      if (r > 0) mem_clr = 1'b0;
      // Reset discards every read still in flight.
      if (v.rst) begin
        q1.delete();
        q3.delete();
      end
      #2;
      exp_ra = (v.erd == 2'b01) ? v.ra0 : (v.erd == 2'b10) ? v.ra1 : '0;
      exp_wa = (v.ewr == 2'b01) ? v.wa0 : (v.ewr == 2'b10) ? v.wa1 : '0;
      exp_wd = (v.ewr == 2'b01) ? v.wd0 : (v.ewr == 2'b10) ? v.wd1 : '0;

      check($sformatf("row%0d rd_ready L1", r), d1_rd_ready, v.erd);
      check($sformatf("row%0d rd_ready L3", r), d3_rd_ready, v.erd);
      check($sformatf("row%0d wr_ready L1", r), d1_wr_ready, v.ewr);
      check($sformatf("row%0d wr_ready L3", r), d3_wr_ready, v.ewr);
      check($sformatf("row%0d read_en", r), d1_re, |v.erd);
      check($sformatf("row%0d read_addr", r), d1_ra, exp_ra);
      check($sformatf("row%0d write_en", r), d1_we, |v.ewr);
      check($sformatf("row%0d write_addr", r), d1_wa, exp_wa);
      check($sformatf("row%0d din", r), d1_din, exp_wd);

      e1v = '0; e1d = '0; e3v = '0; e3d = '0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e1v = q1[0].v; e1d = q1[0].d; void'(q1.pop_front());
      end
      if (q3.size() > 0 && q3[0].due == cyc) begin
        e3v = q3[0].v; e3d = q3[0].d; void'(q3.pop_front());
      end
      check($sformatf("row%0d rsp_valid L1", r), d1_rsp_valid, e1v);
      check($sformatf("row%0d rsp_data L1", r), d1_rsp_data, e1d);
      check($sformatf("row%0d rsp_valid L3", r), d3_rsp_valid, e3v);
      check($sformatf("row%0d rsp_data L3", r), d3_rsp_data, e3d);

      // Read looks up memory before this cycle's write lands.
      if (v.erd != 2'b00) begin
        d = ref_mem[exp_ra[7:0]];
        q1.push_back('{due: cyc + 1, v: v.erd, d: d});
        q3.push_back('{due: cyc + 3, v: v.erd, d: d});
      end
      if (v.ewr != 2'b00) ref_mem[exp_wa[7:0]] = exp_wd;

      @(posedge clk);
      @(negedge clk);
      cyc++;
    end

    check("L1 responses drained", q1.size(), 0);
    check("L3 responses drained", q3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
